// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the 16-bit windowed-register pipeline control logic.
//   - opcode constants and the ALU class bit position
//   - hazard controller FSM state type
//   - phys_reg(): maps a (window, 2-bit field) pair onto the 8-entry physical
//     register file
//   - small decode helpers saying which source fields an instruction reads
// Instruction layout used here: [15:12] opcode, [11:10] Rx, [9:8] Ry.
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam logic [3:0] OP_LOAD   = 4'b0000;
    localparam logic [3:0] OP_STORE  = 4'b0001;
    localparam logic [3:0] OP_BRANCH = 4'b0100;

    // Any instruction with this bit set is an ALU op, whatever the other
    // opcode bits hold.
    localparam int ALU_BIT = 15;

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_RUN   = 3'd1,
        ST_STALL = 3'd2,
        ST_FLUSH = 3'd3,
        ST_HOLD  = 3'd4
    } state_e;

    // Physical register = window * 2 + field, wrapping modulo 8, so window 3
    // field 2 lands on physical register 0.
    function automatic logic [2:0] phys_reg(input logic [1:0] window,
                                            input logic [1:0] field);
        return {window, 1'b0} + {1'b0, field};
    endfunction

    // Rx is a source for ALU, STORE and BRANCH (LOAD writes it instead).
    function automatic logic reads_rx(input logic       is_alu,
                                      input logic [3:0] op);
        return is_alu || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    // Ry is a source for ALU, LOAD (address), STORE and BRANCH.
    function automatic logic reads_ry(input logic       is_alu,
                                      input logic [3:0] op);
        return is_alu || (op == OP_LOAD) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Event counter that sticks at all-ones instead of wrapping.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears q
//   clr   : synchronous clear, takes priority over inc
//   inc   : count one event this cycle
//   q     : current count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Hazard / stall controller sitting beside the ID stage. Detects load-use
// dependencies that forwarding cannot cover, freezes PC and IF/ID while
// injecting a bubble into ID/EX, flushes IF/ID after a taken branch, holds
// the whole pipeline while data memory is busy, and counts stall / flush
// events.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   inst1, window1    instruction in ID and its register window
//   inst2, window2    instruction in EX and its register window
//   branch_taken      ID-stage branch resolved taken (only honoured in RUN)
//   mem_busy          data memory not ready, whole pipeline must hold
//   cnt_clr           synchronous clear of stall_cnt and flush_cnt
//   pc_we, ifid_we    PC / IF/ID write enables
//   ifid_flush        load NOP into IF/ID
//   idex_bubble       load NOP into ID/EX
//   exmem_we          EX/MEM and MEM/WB write enable
//   hold_timeout      sticky flag, mem_busy lasted HOLD_MAX HOLD cycles
//   stall_cnt         saturating count of inserted bubbles
//   flush_cnt         saturating count of IF/ID flushes
// ---------------------------------------------------------------------------
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int HOLD_MAX = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      inst1,
    input  logic [15:0]      inst2,
    input  logic [1:0]       window1,
    input  logic [1:0]       window2,
    input  logic             branch_taken,
    input  logic             mem_busy,
    input  logic             cnt_clr,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_we,
    output logic             hold_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int HOLD_W = (HOLD_MAX < 16) ? 4 : $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(HOLD_MAX);

    // -----------------------------------------------------------------------
    // Load-use detection
    // -----------------------------------------------------------------------
    logic [3:0] op1;
    logic [3:0] op2;
    logic       alu1;
    logic [2:0] rx1_phys;
    logic [2:0] ry1_phys;
    logic [2:0] rx2_phys;
    logic       rx_hit;
    logic       ry_hit;
    logic       load_use;
    logic       unused_inst_bits;

    assign op1      = inst1[15:12];
    assign op2      = inst2[15:12];
    assign alu1     = inst1[ALU_BIT];
    assign rx1_phys = phys_reg(window1, inst1[11:10]);
    assign ry1_phys = phys_reg(window1, inst1[9:8]);
    assign rx2_phys = phys_reg(window2, inst2[11:10]);

    // Only the opcode and register fields matter for hazard detection.
    assign unused_inst_bits = ^{inst1[7:0], inst2[9:0]};

    assign rx_hit = reads_rx(alu1, op1) && (rx1_phys == rx2_phys);
    assign ry_hit = reads_ry(alu1, op1) && (ry1_phys == rx2_phys);

    // A STORE's Rx is the store data, which is forwarded at MEM, so a match
    // on that field alone does not need a bubble. op2 == OP_LOAD already
    // implies inst2[ALU_BIT] is clear.
    always_comb begin
        load_use = 1'b0;
        if (op2 == OP_LOAD) begin
            if (op1 == OP_STORE) begin
                load_use = ry_hit;
            end else begin
                load_use = rx_hit || ry_hit;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    state_e state_q;
    state_e state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // mem_busy is tested first in every active state so that it overrides
    // a stall or flush requested in the same cycle.
    always_comb begin
        state_d     = state_q;
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_we    = 1'b1;

        case (state_q)
            ST_RESET: begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                exmem_we    = 1'b0;
                state_d     = ST_RUN;
            end

            ST_RUN: begin
                if (mem_busy) begin
                    pc_we    = 1'b0;
                    ifid_we  = 1'b0;
                    exmem_we = 1'b0;
                    state_d  = ST_HOLD;
                end else if (load_use) begin
                    // Stall beats a same-cycle branch: the branch operand is
                    // the loaded value and is not valid yet.
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_bubble = 1'b1;
                    state_d     = ST_STALL;
                end else if (branch_taken) begin
                    ifid_flush = 1'b1;
                    state_d    = ST_FLUSH;
                end
            end

            ST_STALL: begin
                // Branch is ignored here; it re-resolves once back in RUN.
                if (mem_busy) begin
                    pc_we    = 1'b0;
                    ifid_we  = 1'b0;
                    exmem_we = 1'b0;
                    state_d  = ST_HOLD;
                end else begin
                    if (load_use) begin
                        pc_we       = 1'b0;
                        ifid_we     = 1'b0;
                        idex_bubble = 1'b1;
                    end
                    state_d = ST_RUN;
                end
            end

            ST_FLUSH: begin
                // IF/ID holds the flushed NOP, so only mem_busy matters.
                if (mem_busy) begin
                    pc_we    = 1'b0;
                    ifid_we  = 1'b0;
                    exmem_we = 1'b0;
                end
                state_d = ST_RUN;
            end

            ST_HOLD: begin
                pc_we    = 1'b0;
                ifid_we  = 1'b0;
                exmem_we = 1'b0;
                state_d  = mem_busy ? ST_HOLD : ST_RUN;
            end

            default: begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                exmem_we    = 1'b0;
                state_d     = ST_RESET;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Hold timer and sticky timeout flag
    // -----------------------------------------------------------------------
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;
    logic              hold_timeout_q;
    logic              hold_timeout_d;

    // Counts every cycle spent in HOLD (including the one where mem_busy
    // drops) and parks at the limit; the flag is raised on the edge where
    // the count arrives there.
    always_comb begin
        hold_cnt_d     = '0;
        hold_timeout_d = hold_timeout_q;
        if (state_q == ST_HOLD) begin
            hold_cnt_d = (hold_cnt_q == HOLD_LIMIT) ? hold_cnt_q : hold_cnt_q + 1'b1;
            if (hold_cnt_d == HOLD_LIMIT) begin
                hold_timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q     <= '0;
            hold_timeout_q <= 1'b0;
        end else begin
            hold_cnt_q     <= hold_cnt_d;
            hold_timeout_q <= hold_timeout_d;
        end
    end

    assign hold_timeout = hold_timeout_q;

    // -----------------------------------------------------------------------
    // Event counters
    // -----------------------------------------------------------------------
    logic stall_inc;
    logic flush_inc;

    // The RESET state drives bubble/flush to initialise the pipe; those are
    // not hazard events and are not counted.
    assign stall_inc = idex_bubble && (state_q != ST_RESET);
    assign flush_inc = ifid_flush  && (state_q != ST_RESET);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (stall_inc),
        .q     (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (flush_inc),
        .q     (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed scenarios followed by randomized traffic; every cycle the DUT
// outputs are compared against a behavioural model built from the pipeline
// rules (register overlap arithmetic plus a few "what happened last cycle"
// flags). Narrow counters are used so saturation is reached quickly.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int TB_CNT_W    = 5;
    localparam int TB_HOLD_MAX = 15;
    localparam int CNT_MAX     = (1 << TB_CNT_W) - 1;
    localparam int N_RANDOM    = 4000;

    // Output bundle order: {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we}
    localparam logic [4:0] O_RESET  = 5'b00110;
    localparam logic [4:0] O_FULL   = 5'b11001;
    localparam logic [4:0] O_FREEZE = 5'b00000;
    localparam logic [4:0] O_BUBBLE = 5'b00011;
    localparam logic [4:0] O_FLUSH  = 5'b11101;

    localparam logic [15:0] NOP = 16'h2000;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [15:0]         inst1 = NOP;
    logic [15:0]         inst2 = NOP;
    logic [1:0]          window1 = 2'd0;
    logic [1:0]          window2 = 2'd0;
    logic                branch_taken = 1'b0;
    logic                mem_busy = 1'b0;
    logic                cnt_clr = 1'b0;
    logic                pc_we;
    logic                ifid_we;
    logic                ifid_flush;
    logic                idex_bubble;
    logic                exmem_we;
    logic                hold_timeout;
    logic [TB_CNT_W-1:0] stall_cnt;
    logic [TB_CNT_W-1:0] flush_cnt;
    logic [4:0]          outs;

    assign outs = {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we};

    hazard_ctrl #(
        .CNT_W    (TB_CNT_W),
        .HOLD_MAX (TB_HOLD_MAX)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inst1        (inst1),
        .inst2        (inst2),
        .window1      (window1),
        .window2      (window2),
        .branch_taken (branch_taken),
        .mem_busy     (mem_busy),
        .cnt_clr      (cnt_clr),
        .pc_we        (pc_we),
        .ifid_we      (ifid_we),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .exmem_we     (exmem_we),
        .hold_timeout (hold_timeout),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_vectors   = 0;
    int n_miscompare = 0;
    int n_cycle     = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompare++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, n_cycle, got, exp);
        end
    endtask

    // ----------------------------- reference model -------------------------
    bit m_first;        // the current cycle is the post-reset initialisation cycle
    bit m_hold;         // memory hold in progress
    bit m_after_stall;  // previous cycle started a stall
    bit m_after_flush;  // previous cycle flushed IF/ID
    int m_hold_run;     // consecutive hold cycles completed
    bit m_tmo;
    int m_stall;
    int m_flush;

    task automatic model_reset();
        m_first       = 1'b1;
        m_hold        = 1'b0;
        m_after_stall = 1'b0;
        m_after_flush = 1'b0;
        m_hold_run    = 0;
        m_tmo         = 1'b0;
        m_stall       = 0;
        m_flush       = 0;
    endtask

    // Dependency test from the instruction-class table: which registers inst1
    // reads, and whether one of them is the register inst2's LOAD writes.
    function automatic bit ref_load_use(input logic [15:0] i1, input logic [15:0] i2,
                                        input logic [1:0] w1, input logic [1:0] w2);
        int  op1 = int'(i1[15:12]);
        int  op2 = int'(i2[15:12]);
        bit  alu = i1[15];
        int  dst = (int'(w2) * 2 + int'(i2[11:10])) % 8;
        int  src_x = (int'(w1) * 2 + int'(i1[11:10])) % 8;
        int  src_y = (int'(w1) * 2 + int'(i1[9:8])) % 8;
        bit  uses_x = alu || (op1 == 4);           // STORE's Rx is forwarded data
        bit  uses_y = alu || (op1 == 0) || (op1 == 1) || (op1 == 4);
        if (op2 != 0) return 1'b0;
        return (uses_x && src_x == dst) || (uses_y && src_y == dst);
    endfunction

    // One clock cycle: drive inputs after the falling edge, compare a little
    // later, then advance the model to what the next rising edge produces.
    task automatic step(input logic [15:0] i1, input logic [15:0] i2,
                        input logic [1:0] w1, input logic [1:0] w2,
                        input logic bt, input logic mb, input logic clr);
        logic [4:0] exp_o;
        bit lu, active, go_hold, go_stall, go_flush;
        @(negedge clk);
        inst1 = i1; inst2 = i2; window1 = w1; window2 = w2;
        branch_taken = bt; mem_busy = mb; cnt_clr = clr;
        #2;
        lu = ref_load_use(i1, i2, w1, w2);
        active = !m_first && !m_hold && !m_after_flush;

        if (m_first)                            exp_o = O_RESET;
        else if (m_hold || mb)                  exp_o = O_FREEZE;
        else if (m_after_flush)                 exp_o = O_FULL;
        else if (lu)                            exp_o = O_BUBBLE;
        else if (bt && !m_after_stall)          exp_o = O_FLUSH;
        else                                    exp_o = O_FULL;

        check_val("outputs", 32'(outs), 32'(exp_o));
        check_val("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        check_val("flush_cnt", 32'(flush_cnt), 32'(m_flush));
        check_val("hold_timeout", 32'(hold_timeout), 32'(m_tmo));

        go_hold  = (m_hold && mb) || (active && mb);
        go_stall = active && !m_after_stall && !mb && lu;
        go_flush = active && !m_after_stall && !mb && !lu && bt;

        if (clr) begin
            m_stall = 0;
            m_flush = 0;
        end else if (!m_first) begin
            if (exp_o[1] && m_stall < CNT_MAX) m_stall++;
            if (exp_o[2] && m_flush < CNT_MAX) m_flush++;
        end

        if (m_hold) begin
            if (m_hold_run < TB_HOLD_MAX) m_hold_run++;
            if (m_hold_run >= TB_HOLD_MAX) m_tmo = 1'b1;
        end else begin
            m_hold_run = 0;
        end

        m_first       = 1'b0;
        m_hold        = go_hold;
        m_after_stall = go_stall;
        m_after_flush = go_flush;
        n_cycle++;
    endtask

    // Pull reset mid-cycle (between edges) and expect an immediate response.
    // Released after a rising edge so the next sampled cycle is the RESET one.
    task automatic async_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("rst_outputs", 32'(outs), 32'(O_RESET));
        check_val("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check_val("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        check_val("rst_hold_timeout", 32'(hold_timeout), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        model_reset();
    endtask

    function automatic logic [15:0] rand_inst1();
        logic [3:0] op;
        case ($urandom_range(0, 4))
            0:       op = 4'(8 + $urandom_range(0, 7));   // ALU
            1:       op = 4'b0000;                         // LOAD
            2:       op = 4'b0001;                         // STORE
            3:       op = 4'b0100;                         // BRANCH
            default: op = 4'(2 + 4 * $urandom_range(0, 1) + $urandom_range(0, 1)); // 2,3,6,7: no regs
        endcase
        return {op, 12'($urandom)};
    endfunction

    function automatic logic [15:0] rand_inst2();
        if ($urandom_range(0, 1) == 0) return {4'b0000, 12'($urandom)};
        return 16'($urandom);
    endfunction

    initial begin
        int busy_left;
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("por_outputs", 32'(outs), 32'(O_RESET));
        check_val("por_stall_cnt", 32'(stall_cnt), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Post-reset initialisation cycle, then a plain LOAD-use stall.
        step(NOP,      NOP,      2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step(16'h8400, 16'h0400, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        check_val("lu_alu_bubble", 32'(idex_bubble), 32'd1);
        step(16'h8400, NOP,      2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        check_val("lu_stall_cnt_1", 32'(stall_cnt), 32'd1);
        check_val("lu_next_full", 32'(outs), 32'(O_FULL));

        // STORE exception: match only on Rx is free, match on Ry stalls.
        step(16'h1400, 16'h0400, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        check_val("store_rx_nostall", 32'(idex_bubble), 32'd0);
        step(16'h1100, 16'h0400, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        check_val("store_ry_stall", 32'(idex_bubble), 32'd1);
        step(NOP,      NOP,      2'd0, 2'd0, 1'b0, 1'b0, 1'b0);

        // Taken branch flushes; with a simultaneous load-use only the stall.
        step(NOP,      NOP,      2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        step(NOP,      NOP,      2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        check_val("br_flush_cnt_1", 32'(flush_cnt), 32'd1);
        step(16'h8400, 16'h0400, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        check_val("br_lu_no_flush", 32'(ifid_flush), 32'd0);
        step(NOP,      NOP,      2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        check_val("br_lu_flush_cnt", 32'(flush_cnt), 32'd1);

        // Window wrap: window 3 Rx=2 is physical r0.
        step(16'h8000, 16'h0800, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0);
        check_val("wrap_stall", 32'(idex_bubble), 32'd1);
        step(NOP,      NOP,      2'd0, 2'd0, 1'b0, 1'b0, 1'b0);

        // Long memory hold while a load-use is pending.
        for (int i = 0; i < 20; i++) begin
            step(16'h8400, 16'h0400, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        end
        check_val("hold_timeout_set", 32'(hold_timeout), 32'd1);
        step(16'h8400, 16'h0400, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step(16'h8400, 16'h0400, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        check_val("hold_resume_bubble", 32'(idex_bubble), 32'd1);

        // Counter clear leaves the sticky timeout alone.
        step(NOP,      NOP,      2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        step(NOP,      NOP,      2'd0, 2'd0, 1'b0, 1'b0, 1'b0);

        // Reset while stalled.
        step(16'h8400, 16'h0400, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        async_reset();
        step(NOP,      NOP,      2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step(NOP,      NOP,      2'd0, 2'd0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic with memory-busy bursts and occasional resets.
        busy_left = 0;
        for (int i = 0; i < N_RANDOM; i++) begin
            logic mb;
            if (busy_left == 0 && $urandom_range(0, 99) < 5) begin
                busy_left = $urandom_range(1, 20);
            end
            mb = (busy_left != 0);
            if (busy_left != 0) busy_left--;
            step(rand_inst1(), rand_inst2(), 2'($urandom), 2'($urandom),
                 1'($urandom_range(0, 3) == 0), mb,
                 1'($urandom_range(0, 99) == 0));
            if ($urandom_range(0, 999) < 3) begin
                async_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompare);
        $finish;
    end

endmodule
